sensor_freq_counter: RTL and testbench

//  Measures the output frequency of the colour sensor (TCS3200-style square wave) by counting
//  its rising edges over a fixed gate window of clk cycles. Sits directly upstream of the

---
 rtl/sensor_freq_counter.sv | 129 ++++++++++++
 tb/tb_sensor_freq_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_freq_counter.sv
// rtl/sensor_freq_counter.sv - gated rising-edge counter for a colour-sensor square wave
// Optional input deglitch filter: define FREQCNT_DEGLITCH_EN.
module sensor_freq_counter #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensorFreq,
  input  logic               start,
  output logic               busy,
  output logic [COUNT_W-1:0] freq,
  output logic               freq_valid,
  output logic               overflow
);

  localparam int MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] GATE_LOAD   = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? TIMER_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [COUNT_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic                 sync1;
  logic                 sync2;
  logic                 hist;
  logic                 level;
  logic                 edge_det;
  logic [TIMER_W-1:0]   timer;
  logic [COUNT_W-1:0]   acc;
  logic [COUNT_W-1:0]   acc_upd;
  logic                 sat;
  logic                 sat_upd;
  logic                 count_en;

`ifdef FREQCNT_DEGLITCH_EN
  // hist doubles as the filtered level; it only follows two agreeing samples
  logic sync_d;
  assign level = (sync2 == sync_d) ? sync2 : hist;
`else
  assign level = sync2;
`endif

  assign edge_det   = level & ~hist;
  assign busy       = (state != IDLE);
  assign freq_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (SETTLE_CYCLES > 0) ? SETTLE : GATE;
      SETTLE:  if (timer == '0) state_next = GATE;
      GATE:    if (timer == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Saturating accumulate; the final GATE cycle's edge is folded in when freq loads
  always_comb begin
    count_en = (state == GATE) && edge_det;
    acc_upd  = acc;
    sat_upd  = sat;
    if (count_en) begin
      if (acc == ACC_MAX) begin
        sat_upd = 1'b1;
      end else begin
        acc_upd = acc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      hist     <= 1'b0;
      timer    <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
`ifdef FREQCNT_DEGLITCH_EN
      sync_d   <= 1'b0;
`endif
    end else begin
      sync1 <= sensorFreq;
      sync2 <= sync1;
      hist  <= level;
`ifdef FREQCNT_DEGLITCH_EN
      sync_d <= sync2;
`endif
      if (state == IDLE && state_next == SETTLE) begin
        timer <= SETTLE_LOAD;
      end else if (state != GATE && state_next == GATE) begin
        timer <= GATE_LOAD;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (state != GATE && state_next == GATE) begin
        acc <= '0;
        sat <= 1'b0;
      end else begin
        acc <= acc_upd;
        sat <= sat_upd;
      end

      if (state == GATE && state_next == DONE) begin
        freq     <= acc_upd;
        overflow <= sat_upd;
      end
    end
  end

endmodule

// File: tb/tb_sensor_freq_counter.sv
// tb/tb_sensor_freq_counter.sv - directed self-checking bench for sensor_freq_counter
// Expectations switch with FREQCNT_DEGLITCH_EN where the filter changes the count.
module tb_sensor_freq_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor;
  logic       start;
  logic       busy, freq_valid, overflow;
  logic [7:0] freq;
  logic       busy5, fv5, ov5;
  logic [4:0] freq5;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int ph    = 0;

  int         first_v, n_v;
  logic [7:0] f8;
  logic       o8, o5, busy_after;
  logic [4:0] f5;

  always #5 clk = ~clk;

  sensor_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .COUNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sensorFreq(sensor), .start(start),
    .busy(busy), .freq(freq), .freq_valid(freq_valid), .overflow(overflow)
  );

  sensor_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .COUNT_W(5)) u_dut5 (
    .clk(clk), .rst(rst), .sensorFreq(sensor), .start(start),
    .busy(busy5), .freq(freq5), .freq_valid(fv5), .overflow(ov5)
  );

  // mode 0: low, 1: high, 2: toggle every clk, 3: 1-clk pulse per 10, 4: square period 10
  initial begin
    sensor = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 10;
      case (mode)
        0:       sensor = 1'b0;
        1:       sensor = 1'b1;
        2:       sensor = ~sensor;
        3:       sensor = (ph == 0);
        default: sensor = (ph < 5);
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input int m);
    mode = m;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_meas(input int p1, input int p2, input int p3);
    first_v    = -1;
    n_v        = 0;
    f8         = 'x;
    o8         = 1'bx;
    f5         = 'x;
    o5         = 1'bx;
    busy_after = 1'bx;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = (c == p1) || (c == p2) || (c == p3);
      if (freq_valid) begin
        n_v++;
        if (first_v < 0) begin
          first_v = c;
          f8 = freq;
          o8 = overflow;
          f5 = freq5;
          o5 = ov5;
        end
      end
      if (first_v > 0 && c == first_v + 1) busy_after = busy;
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_freq", freq, 0);
    check("reset_valid", freq_valid, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b0;

    set_mode(4);
    run_meas(-1, -1, -1);
    check("t1_latency", first_v, 111);
    check("t1_valid_count", n_v, 1);
    check("t1_freq", f8, 10);
    check("t1_overflow", o8, 0);
    check("t1_busy_after", busy_after, 0);
    check("t1_freq_w5", f5, 10);
    check("t1_freq_held", freq, 10);

    run_meas(5, 50, 110);
    check("t4_latency", first_v, 111);
    check("t4_valid_count", n_v, 1);
    check("t4_freq", f8, 10);

    set_mode(0);
    run_meas(-1, -1, -1);
    check("t2_low_freq", f8, 0);
    check("t2_low_overflow", o8, 0);
    set_mode(1);
    run_meas(-1, -1, -1);
    check("t2_high_freq", f8, 0);

    set_mode(2);
    run_meas(-1, -1, -1);
`ifdef FREQCNT_DEGLITCH_EN
    check("t3_w5_freq", f5, 0);
    check("t3_w5_overflow", o5, 0);
    check("t3_w8_freq", f8, 0);
`else
    check("t3_w5_freq", f5, 31);
    check("t3_w5_overflow", o5, 1);
    check("t3_w8_freq", f8, 50);
    check("t3_w8_overflow", o8, 0);
`endif
    set_mode(4);
    run_meas(-1, -1, -1);
    check("t3_w5_recover_freq", f5, 10);
    check("t3_w5_recover_overflow", o5, 0);

    set_mode(3);
    run_meas(-1, -1, -1);
`ifdef FREQCNT_DEGLITCH_EN
    check("t6_pulse_freq", f8, 0);
`else
    check("t6_pulse_freq", f8, 10);
`endif

    set_mode(4);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("t5_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_freq", freq, 0);
    check("t5_rst_valid", freq_valid, 0);
    n_v = 0;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (freq_valid) n_v++;
    end
    check("t5_no_valid", n_v, 0);
    run_meas(-1, -1, -1);
    check("t5_after_freq", f8, 10);
    check("t5_after_latency", first_v, 111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
